// File: rtl/video_pkg.sv
// Shared definitions for the video pattern source: pattern codes, bar colour table
// and the line/frame region decoder used by the timing core.
package video_pkg;

   typedef enum logic [1:0] {
      PAT_BAR   = 2'd0,
      PAT_GRID  = 2'd1,
      PAT_GRAD  = 2'd2,
      PAT_SOLID = 2'd3
   } pat_e;

   typedef enum logic [1:0] {
      REG_SYNC,
      REG_BACK,
      REG_ACTIVE,
      REG_FRONT
   } region_e;

   // {R,G,B} channel masks; each set bit expands to an all-ones channel.
   // Entry 0 is rightmost: white, yellow, cyan, green, magenta, red, blue, black.
   localparam logic [7:0][2:0] COLOUR_LUT = {
      3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
   };

   // Limits are cumulative end points of each region within the line or frame.
   function automatic region_e region_of(input int unsigned cnt,
                                         input int unsigned sync_end,
                                         input int unsigned back_end,
                                         input int unsigned active_end,
                                         input int unsigned front_end);
      if (cnt < sync_end)        return REG_SYNC;
      else if (cnt < back_end)   return REG_BACK;
      else if (cnt < active_end) return REG_ACTIVE;
      else if (cnt < front_end)  return REG_FRONT;
      // Counts beyond the frame never persist; the next count wraps into sync.
      return REG_SYNC;
   endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Video output bus from the pattern source towards the TMDS encoder.
interface video_pattern_gen_if #(
   parameter int DATA_W = 8,
   parameter int X_W    = 10,
   parameter int Y_W    = 9
);
   logic                  hsync;
   logic                  vsync;
   logic                  de;
   logic [3*DATA_W-1:0]   rgb;
   logic [X_W-1:0]        pix_x;
   logic [Y_W-1:0]        pix_y;
   logic                  frame_start;

   modport master (output hsync, vsync, de, rgb, pix_x, pix_y, frame_start);
   modport slave  (input  hsync, vsync, de, rgb, pix_x, pix_y, frame_start);
endinterface

// File: rtl/video_timing_core.sv
// Horizontal/vertical raster counters with sync, data-enable and active-position decode.
// Decode outputs are combinational from the counter state; the top level registers them.
module video_timing_core
   import video_pkg::*;
#(
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter bit SYNC_POL = 1'b0,
   parameter int X_W      = 10,
   parameter int Y_W      = 9
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           enable,
   output logic           hsync,
   output logic           vsync,
   output logic           de,
   output logic           first,
   output logic           line_last,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int HC_W    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int VC_W    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

   logic [HC_W-1:0] h_cnt_q, h_cnt_d, h_off;
   logic [VC_W-1:0] v_cnt_q, v_cnt_d, v_off;
   region_e         h_reg, v_reg;

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (!enable) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (h_cnt_q == HC_W'(H_TOTAL - 1)) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == VC_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
      end else begin
         h_cnt_d = h_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // A parked core reports blanking with inactive syncs.
   always_comb begin
      h_reg     = region_of(32'(h_cnt_q), H_SYNC, H_SYNC + H_BACK,
                            H_SYNC + H_BACK + H_ACTIVE, H_TOTAL);
      v_reg     = region_of(32'(v_cnt_q), V_SYNC, V_SYNC + V_BACK,
                            V_SYNC + V_BACK + V_ACTIVE, V_TOTAL);
      h_off     = h_cnt_q - HC_W'(H_SYNC + H_BACK);
      v_off     = v_cnt_q - VC_W'(V_SYNC + V_BACK);
      hsync     = ~SYNC_POL;
      vsync     = ~SYNC_POL;
      de        = 1'b0;
      first     = 1'b0;
      line_last = 1'b0;
      x         = '0;
      y         = '0;
      if (enable) begin
         if (h_reg == REG_SYNC) hsync = SYNC_POL;
         if (v_reg == REG_SYNC) vsync = SYNC_POL;
         de    = (h_reg == REG_ACTIVE) && (v_reg == REG_ACTIVE);
         first = (h_cnt_q == '0) && (v_cnt_q == '0);
         if (de) begin
            x = X_W'(h_off);
            y = Y_W'(v_off);
         end
         line_last = de && (x == X_W'(H_ACTIVE - 1));
      end
   end

endmodule

// File: rtl/video_pattern_gen.sv
// Parametrised video timing and test-pattern source (bar, grid, gradient, solid).
// Pattern selection is latched at the start of each frame; every output is registered.
module video_pattern_gen
   import video_pkg::*;
#(
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int N_BARS   = 8,
   parameter int GRID     = 32,
   parameter bit SYNC_POL = 1'b0,
   parameter int DATA_W   = 8
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                enable,
   input  logic [1:0]          pat_sel,
   input  logic [3*DATA_W-1:0] solid_rgb,
   video_pattern_gen_if.master vid
);

   localparam int X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int BAR_W = H_ACTIVE / N_BARS;
   localparam int BC_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam int BI_W  = (N_BARS > 1) ? $clog2(N_BARS) : 1;
   localparam int G_W   = $clog2(GRID);

   logic           t_hsync, t_vsync, t_de, t_first, t_line_last;
   logic [X_W-1:0] t_x;
   logic [Y_W-1:0] t_y;

   video_timing_core #(
      .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
      .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT),
      .SYNC_POL(SYNC_POL), .X_W(X_W), .Y_W(Y_W)
   ) u_timing (
      .clk(sys_clk), .rst(sys_rst), .enable(enable),
      .hsync(t_hsync), .vsync(t_vsync), .de(t_de), .first(t_first),
      .line_last(t_line_last), .x(t_x), .y(t_y)
   );

   function automatic logic [3*DATA_W-1:0] expand(input logic [2:0] m);
      return {{DATA_W{m[2]}}, {DATA_W{m[1]}}, {DATA_W{m[0]}}};
   endfunction

   pat_e                pat_q, pat_d;
   logic [BC_W-1:0]     bar_cnt_q, bar_cnt_d;
   logic [BI_W-1:0]     bar_idx_q, bar_idx_d;
   logic [G_W-1:0]      gx_q, gx_d, gy_q, gy_d;
   logic [3*DATA_W-1:0] colour;
   logic [X_W+DATA_W-1:0] x_ext;
   logic                grid_on;

   logic                hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
   logic                frame_start_q, frame_start_d;
   logic [3*DATA_W-1:0] rgb_q, rgb_d;
   logic [X_W-1:0]      pix_x_q, pix_x_d;
   logic [Y_W-1:0]      pix_y_q, pix_y_d;

   // Sub-counters track the position being decoded this cycle; they advance
   // through active pixels and fall back to zero in blanking.
   always_comb begin
      pat_d     = t_first ? pat_e'(pat_sel) : pat_q;
      bar_cnt_d = '0;
      bar_idx_d = '0;
      gx_d      = '0;
      gy_d      = gy_q;
      if (t_de && !t_line_last) begin
         bar_cnt_d = (bar_cnt_q == BC_W'(BAR_W - 1)) ? '0 : bar_cnt_q + 1'b1;
         bar_idx_d = bar_idx_q;
         if (bar_cnt_q == BC_W'(BAR_W - 1) && bar_idx_q != BI_W'(N_BARS - 1))
            bar_idx_d = bar_idx_q + 1'b1;
         gx_d = (gx_q == G_W'(GRID - 1)) ? '0 : gx_q + 1'b1;
      end
      if (t_line_last) gy_d = (gy_q == G_W'(GRID - 1)) ? '0 : gy_q + 1'b1;
      if (t_first)     gy_d = '0;
   end

   always_comb begin
      x_ext   = {{DATA_W{1'b0}}, t_x};
      grid_on = (gx_q == '0) || (gy_q == '0) ||
                (t_x == X_W'(H_ACTIVE - 1)) || (t_y == Y_W'(V_ACTIVE - 1));
      case (pat_q)
         PAT_BAR:  colour = expand(COLOUR_LUT[3'(bar_idx_q)]);
         PAT_GRID: colour = grid_on ? {3*DATA_W{1'b1}} : '0;
         PAT_GRAD: colour = {3{x_ext[DATA_W-1:0]}};
         default:  colour = solid_rgb;
      endcase
      hsync_d       = t_hsync;
      vsync_d       = t_vsync;
      de_d          = t_de;
      rgb_d         = t_de ? colour : '0;
      pix_x_d       = t_x;
      pix_y_d       = t_y;
      frame_start_d = t_first;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pat_q         <= PAT_BAR;
         bar_cnt_q     <= '0;
         bar_idx_q     <= '0;
         gx_q          <= '0;
         gy_q          <= '0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         de_q          <= 1'b0;
         rgb_q         <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         frame_start_q <= 1'b0;
      end else begin
         pat_q         <= pat_d;
         bar_cnt_q     <= bar_cnt_d;
         bar_idx_q     <= bar_idx_d;
         gx_q          <= gx_d;
         gy_q          <= gy_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         rgb_q         <= rgb_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vid.hsync       = hsync_q;
   assign vid.vsync       = vsync_q;
   assign vid.de          = de_q;
   assign vid.rgb         = rgb_q;
   assign vid.pix_x       = pix_x_q;
   assign vid.pix_y       = pix_y_q;
   assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: a reduced raster instance for pattern, enable and reset
// behaviour, plus a default 640x480 instance for line timing and bar colours.
module tb_video_pattern_gen;

   localparam int HS = 4, HB = 3, HA = 20, HF = 2;
   localparam int VS = 2, VB = 2, VA = 12, VF = 1;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int DW = 4, XW = 5, YW = 4;
   localparam logic [31:0] IDLE = {7'b0, 1'b1, 1'b1, 1'b0, 12'h000, 5'd0, 4'd0, 1'b0};
   localparam int DBASE = 35 * 800 + 144;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, en;
   logic [1:0]    pat;
   logic [11:0]   solid;
   logic          rst_def, en_def, def_done;
   logic [1:0]    pat_def;
   logic [23:0]   solid_def;

   video_pattern_gen_if #(.DATA_W(DW), .X_W(XW), .Y_W(YW)) s_if ();
   video_pattern_gen_if #(.DATA_W(8), .X_W(10), .Y_W(9)) d_if ();

   video_pattern_gen #(
      .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
      .N_BARS(3), .GRID(4), .SYNC_POL(1'b0), .DATA_W(DW)
   ) dut (
      .sys_clk(clk), .sys_rst(rst), .enable(en), .pat_sel(pat),
      .solid_rgb(solid), .vid(s_if)
   );

   video_pattern_gen dut_def (
      .sys_clk(clk), .sys_rst(rst_def), .enable(en_def), .pat_sel(pat_def),
      .solid_rgb(solid_def), .vid(d_if)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference outputs for raster position (h, v) of the reduced instance.
   function automatic logic [31:0] model(input int h, input int v, input logic [1:0] p,
                                         input logic [11:0] s);
      logic       hs, vsy, de;
      int         x, y, b;
      logic [11:0] rgb;
      hs  = (h >= HS);
      vsy = (v >= VS);
      de  = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
      x   = de ? h - HS - HB : 0;
      y   = de ? v - VS - VB : 0;
      b   = (x / 6 > 2) ? 2 : x / 6;
      rgb = 12'h000;
      if (de) begin
         case (p)
            2'd0:    rgb = (b == 0) ? 12'hFFF : (b == 1) ? 12'hFF0 : 12'h0FF;
            2'd1:    rgb = (x % 4 == 0 || y % 4 == 0 || x == HA - 1 || y == VA - 1) ? 12'hFFF : 12'h000;
            2'd2:    rgb = {3{4'(x)}};
            default: rgb = s;
         endcase
      end
      return {7'b0, hs, vsy, de, rgb, 5'(x), 4'(y), (h == 0 && v == 0)};
   endfunction

   function automatic logic [31:0] obs_s();
      return {7'b0, s_if.hsync, s_if.vsync, s_if.de, s_if.rgb, s_if.pix_x, s_if.pix_y,
              s_if.frame_start};
   endfunction

   int          ph = 0, pv = 0, lh = -1, lv = -1;
   logic [1:0]  mpat = 2'd0;
   logic [31:0] exp_v;

   task automatic tick();
      @(posedge clk);
      if (rst || !en) begin
         exp_v = IDLE;
         ph = 0; pv = 0; lh = -1; lv = -1;
         if (rst) mpat = 2'd0;
      end else begin
         exp_v = model(ph, pv, mpat, solid);
         if (ph == 0 && pv == 0) mpat = pat;
         lh = ph; lv = pv;
         ph++;
         if (ph == HT) begin
            ph = 0;
            pv = (pv == VT - 1) ? 0 : pv + 1;
         end
      end
      @(negedge clk);
      check_val("raster", obs_s(), exp_v);
   endtask

   task automatic run_to(input int h, input int v);
      bit found = 1'b0;
      for (int i = 0; i < 2 * HT * VT && !found; i++) begin
         tick();
         if (lh == h && lv == v) found = 1'b1;
      end
      check_val("run_to_reached", 32'(found), 32'd1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; pat = 2'd0; solid = 12'h000;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_val("rst_hsync", 32'(s_if.hsync), 32'd1);
      check_val("rst_vsync", 32'(s_if.vsync), 32'd1);
      check_val("rst_de", 32'(s_if.de), 32'd0);
      check_val("rst_rgb", 32'(s_if.rgb), 32'h0);
      check_val("rst_fs", 32'(s_if.frame_start), 32'd0);
      rst = 1'b0;
      tick();
      check_val("first_fs", 32'(s_if.frame_start), 32'd1);
      check_val("first_hsync", 32'(s_if.hsync), 32'd0);

      // Bars: widths 6, 6, 8 with N_BARS = 3 across 20 pixels
      run_to(7, 4);  check_val("bar_x0", 32'(s_if.rgb), 32'hFFF);
      check_val("bar_x0_de", 32'(s_if.de), 32'd1);
      run_to(12, 4); check_val("bar_x5", 32'(s_if.rgb), 32'hFFF);
      run_to(13, 4); check_val("bar_x6", 32'(s_if.rgb), 32'hFF0);
      run_to(18, 4); check_val("bar_x11", 32'(s_if.rgb), 32'hFF0);
      run_to(19, 4); check_val("bar_x12", 32'(s_if.rgb), 32'h0FF);
      run_to(26, 4); check_val("bar_x19", 32'(s_if.rgb), 32'h0FF);
      check_val("bar_pix_x19", 32'(s_if.pix_x), 32'd19);
      run_to(27, 4); check_val("front_de", 32'(s_if.de), 32'd0);
      check_val("front_rgb", 32'(s_if.rgb), 32'h0);

      // Mid-frame switch to solid takes effect on the next frame
      run_to(10, 8);
      pat = 2'd3; solid = 12'h123;
      run_to(10, 9);  check_val("mode_still_bar", 32'(s_if.rgb), 32'hFFF);
      run_to(26, 15); check_val("mode_last_bar", 32'(s_if.rgb), 32'h0FF);
      run_to(10, 4);  check_val("solid_active", 32'(s_if.rgb), 32'h123);
      run_to(3, 5);   check_val("solid_blank", 32'(s_if.rgb), 32'h000);
      run_to(20, 15); check_val("solid_last", 32'(s_if.rgb), 32'h123);

      pat = 2'd1;
      run_to(0, 0);
      run_to(7, 5);  check_val("grid_x0", 32'(s_if.rgb), 32'hFFF);
      run_to(8, 5);  check_val("grid_x1", 32'(s_if.rgb), 32'h000);
      run_to(11, 5); check_val("grid_x4", 32'(s_if.rgb), 32'hFFF);
      run_to(26, 5); check_val("grid_xlast", 32'(s_if.rgb), 32'hFFF);
      run_to(8, 8);  check_val("grid_y4", 32'(s_if.rgb), 32'hFFF);
      run_to(9, 14); check_val("grid_y10", 32'(s_if.rgb), 32'h000);
      run_to(9, 15); check_val("grid_ylast", 32'(s_if.rgb), 32'hFFF);

      pat = 2'd2;
      run_to(0, 0);
      run_to(10, 4); check_val("grad_x3", 32'(s_if.rgb), 32'h333);
      run_to(22, 4); check_val("grad_x15", 32'(s_if.rgb), 32'hFFF);
      run_to(23, 4); check_val("grad_x16", 32'(s_if.rgb), 32'h000);
      run_to(25, 4); check_val("grad_x18", 32'(s_if.rgb), 32'h222);

      // Park the timing mid-line, then resume with a fresh frame
      run_to(14, 6);
      en = 1'b0;
      tick();
      check_val("park_hsync", 32'(s_if.hsync), 32'd1);
      check_val("park_de", 32'(s_if.de), 32'd0);
      repeat (9) tick();
      en = 1'b1;
      tick();
      check_val("resume_fs", 32'(s_if.frame_start), 32'd1);
      run_to(HT - 1, VT - 1);
      tick();
      check_val("next_fs", 32'(s_if.frame_start), 32'd1);

      // Asynchronous reset in the middle of an active line
      run_to(10, 5);
      check_val("pre_rst_de", 32'(s_if.de), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_val("async_rst_de", 32'(s_if.de), 32'd0);
      check_val("async_rst_rgb", 32'(s_if.rgb), 32'h0);
      check_val("async_rst_hsync", 32'(s_if.hsync), 32'd1);
      check_val("async_rst_pix_x", 32'(s_if.pix_x), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_val("post_rst_fs", 32'(s_if.frame_start), 32'd1);
      run_to(15, 4);
      check_val("post_rst_grad", 32'(s_if.rgb), 32'h888);

      for (int i = 0; i < 40000 && !def_done; i++) @(posedge clk);
      check_val("default_done", 32'(def_done), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Default 640x480 instance: sync widths and bar colours on the first active line
   initial begin
      def_done = 1'b0; en_def = 1'b1; pat_def = 2'd0; solid_def = 24'h0;
      rst_def = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_val("def_rst_hsync", 32'(d_if.hsync), 32'd1);
      check_val("def_rst_vsync", 32'(d_if.vsync), 32'd1);
      rst_def = 1'b0;
      for (int k = 0; k <= DBASE + 640; k++) begin
         @(posedge clk);
         @(negedge clk);
         case (k)
            0:           check_val("def_fs0", 32'(d_if.frame_start), 32'd1);
            1:           check_val("def_fs1", 32'(d_if.frame_start), 32'd0);
            95:          check_val("def_hsync_end", 32'(d_if.hsync), 32'd0);
            96:          check_val("def_hsync_off", 32'(d_if.hsync), 32'd1);
            800:         check_val("def_hsync_line1", 32'(d_if.hsync), 32'd0);
            1599:        check_val("def_vsync_end", 32'(d_if.vsync), 32'd0);
            1600:        check_val("def_vsync_off", 32'(d_if.vsync), 32'd1);
            DBASE - 1:   check_val("def_pre_de", 32'(d_if.de), 32'd0);
            DBASE:       check_val("def_x0", {8'h0, d_if.rgb}, 32'hFFFFFF);
            DBASE + 79:  check_val("def_x79", {8'h0, d_if.rgb}, 32'hFFFFFF);
            DBASE + 80:  check_val("def_x80", {8'h0, d_if.rgb}, 32'hFFFF00);
            DBASE + 159: check_val("def_x159", {8'h0, d_if.rgb}, 32'hFFFF00);
            DBASE + 160: check_val("def_x160", {8'h0, d_if.rgb}, 32'h00FFFF);
            DBASE + 560: check_val("def_x560", {8'h0, d_if.rgb}, 32'h000000);
            DBASE + 639: check_val("def_x639", 32'(d_if.pix_x), 32'd639);
            DBASE + 640: check_val("def_post_de", 32'(d_if.de), 32'd0);
            default: ;
         endcase
      end
      def_done = 1'b1;
   end

endmodule
